grid_game_core: RTL
===================

GRID_GAME_CORE -- requirements
Module: grid_game_core

Interface
REQ-001 Parameter GRID_N, default 3, meaning cells per grid side (2..8); CELLS = GRID_N*GRID_N.
REQ-002 Parameter TICKS_PER_SEC, default 50_000_000, meaning clk cycles per game second.
REQ-003 Parameter SHOW_SEC, default 3, meaning seconds the target is displayed (1..15).
REQ-004 Parameter PLAY_SEC, default 5, meaning seconds allowed for the player's pick (1..15).
REQ-005 Parameter ROUNDS, default 4, meaning consecutive correct picks needed to win (1..15).
REQ-006 Parameter SEED, default 16'hACE1, meaning LFSR reset value (nonzero).
REQ-007 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-009 start  in  1  one-cycle pulse, already debounced; begins or restarts a game.
REQ-010 step  in  1  one-cycle pulse; advances the player cursor.
REQ-011 select  in  1  one-cycle pulse; confirms the cursor cell.
REQ-012 state  out  3  encoded FSM state (IDLE=0, PICK=1, SHOW=2, PLAY=3, CHECK=4, WIN=5, LOSE=6).
REQ-013 target  out  CW  random target cell index, CW = clog2(CELLS).
REQ-014 cursor  out  CW  player cell index.
REQ-015 show_target  out  1  high only in SHOW.
REQ-016 sec_left  out  4  seconds remaining in SHOW or PLAY, else 0.
REQ-017 round  out  4  rounds completed this game.
REQ-018 win, lose  out  1 each  level outputs, high only in WIN / LOSE respectively.

Function
REQ-019 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle in all states.
REQ-020 A tick counter SHALL count 0..TICKS_PER_SEC-1, pulse sec_tick on wrap, and clear to 0 on every state change.
REQ-021 IDLE: start -> PICK with round=0, cursor=0.
REQ-022 PICK: if LFSR[CW-1:0] < CELLS, latch it into target and go to SHOW with sec_left=SHOW_SEC; else stay in PICK (rejection, no modulo).
REQ-023 SHOW: sec_tick decrements sec_left; when a sec_tick occurs while sec_left==1 -> PLAY with sec_left=PLAY_SEC, cursor=0.
REQ-024 PLAY: step increments cursor, wrapping CELLS-1 -> 0; select -> CHECK; sec_tick with sec_left==1 -> LOSE.
REQ-025 PLAY: select and timeout in same cycle -> select wins (CHECK).
REQ-026 PLAY: step and select in same cycle -> CHECK compares the pre-increment cursor; cursor not incremented.
REQ-027 CHECK (exactly one cycle): cursor==target -> round+1, then WIN if new round==ROUNDS else PICK; mismatch -> LOSE, round unchanged.
REQ-028 WIN/LOSE: hold; start -> PICK with round=0, cursor=0.
REQ-029 start SHALL be ignored in PICK, SHOW, PLAY and CHECK; step/select ignored outside PLAY.
REQ-030 All outputs SHALL be registered; sec_left SHALL read 0 outside SHOW and PLAY.

Reset
REQ-031 rst low SHALL asynchronously force state=IDLE, LFSR=SEED, tick counter=0, target=0, cursor=0, sec_left=0, round=0, show_target=0, win=0, lose=0.
REQ-032 Reset asserted mid-game SHALL abandon the game; no pulse is remembered after release.
REQ-033 First state change after rst release SHALL require a start pulse.

Verification (GRID_N=3, TICKS_PER_SEC=4, SHOW_SEC=2, PLAY_SEC=3, ROUNDS=2)
REQ-034 Reset then start -> PICK within 1 cycle; target<9 always; SHOW with sec_left=2, show_target=1 for exactly 8 cycles, then PLAY with sec_left=3.
REQ-035 In PLAY, pulse step (target) times then select -> CHECK for 1 cycle, round=1, PICK; repeat -> WIN=1, round=2, held until start.
REQ-036 In PLAY, no input for 12 cycles -> LOSE=1, round unchanged; start -> PICK, round=0.
REQ-037 Cursor at 8, step -> cursor=0; step+select same cycle at cursor=target -> correct round, cursor unchanged.
REQ-038 select on the same cycle as the final timeout tick -> CHECK, not LOSE; rst low during SHOW -> all outputs at reset values immediately, start ignored while rst low.
REQ-039 GRID_N=5 build: target always <25 over 10_000 PICKs; all 25 values observed.

Source files
------------

// File: rtl/grid_game_core.sv
// grid_game_core: memory-grid game. A random target cell is shown for SHOW_SEC
//   seconds, then the player has PLAY_SEC seconds to step a cursor onto it and select.
// Latency: every output is a register; an input pulse shows its effect on the outputs
//   one clock after the edge that samples it.
// Backpressure: none. start/step/select are single-cycle pulses. A pulse the current
//   state does not use is dropped, not queued.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        begin a game (IDLE) or restart one (WIN/LOSE)
//   step_i         advance the cursor (PLAY only)
//   select_i       confirm the cursor cell (PLAY only)
//   state_o        IDLE=0 PICK=1 SHOW=2 PLAY=3 CHECK=4 WIN=5 LOSE=6
//   target_o       target cell index
//   cursor_o       player cell index
//   show_target_o  high while the target is displayed (SHOW)
//   sec_left_o     seconds remaining in SHOW/PLAY, 0 elsewhere
//   round_o        correct picks so far in this game
//   win_o, lose_o  level flags for the WIN and LOSE states
module grid_game_core #(
  parameter int          GRID_N        = 3,
  parameter int          TICKS_PER_SEC = 50_000_000,
  parameter int          SHOW_SEC      = 3,
  parameter int          PLAY_SEC      = 5,
  parameter int          ROUNDS        = 4,
  parameter logic [15:0] SEED          = 16'hACE1,
  localparam int         CELLS         = GRID_N * GRID_N,
  localparam int         CW            = $clog2(CELLS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          step_i,
  input  logic          select_i,
  output logic [2:0]    state_o,
  output logic [CW-1:0] target_o,
  output logic [CW-1:0] cursor_o,
  output logic          show_target_o,
  output logic [3:0]    sec_left_o,
  output logic [3:0]    round_o,
  output logic          win_o,
  output logic          lose_o
);

  // A one-cycle second (TICKS_PER_SEC == 1) still needs a 1-bit counter.
  localparam int TW = ($clog2(TICKS_PER_SEC) < 1) ? 1 : $clog2(TICKS_PER_SEC);

  localparam logic [TW-1:0] TICK_MAX   = TW'(TICKS_PER_SEC - 1);
  localparam logic [CW:0]   CELLS_W    = (CW + 1)'(CELLS);
  localparam logic [CW-1:0] CELL_MAX   = CW'(CELLS - 1);
  localparam logic [3:0]    SHOW_SEC_W = 4'(SHOW_SEC);
  localparam logic [3:0]    PLAY_SEC_W = 4'(PLAY_SEC);
  localparam logic [3:0]    ROUNDS_W   = 4'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PICK  = 3'd1,
    S_SHOW  = 3'd2,
    S_PLAY  = 3'd3,
    S_CHECK = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_e;

  state_e        state_q;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [TW-1:0] tick_q;
  logic [CW-1:0] target_q;
  logic [CW-1:0] cursor_q;
  logic [3:0]    sec_left_q;
  logic [3:0]    round_q;
  logic          show_q;
  logic          win_q;
  logic          lose_q;

  // ---------------------------------------------------------------------------
  // Random source: x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
  // It free-runs in every state, so the target depends on how long the
  // player took, which is the only entropy available.
  // ---------------------------------------------------------------------------
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Helper terms for the FSM.
  // ---------------------------------------------------------------------------
  logic          sec_tick;
  logic [CW-1:0] cand;
  logic          cand_ok;
  logic [CW-1:0] cursor_inc;
  logic [3:0]    round_inc;
  logic          last_sec;

  assign sec_tick   = (tick_q == TICK_MAX);
  // A candidate outside the grid is rejected and redrawn on the next cycle.
  // Reducing it modulo CELLS instead would bias the low cells.
  assign cand       = lfsr_q[CW-1:0];
  assign cand_ok    = ({1'b0, cand} < CELLS_W);
  assign cursor_inc = (cursor_q == CELL_MAX) ? '0 : cursor_q + CW'(1);
  assign round_inc  = round_q + 4'd1;
  assign last_sec   = sec_tick && (sec_left_q == 4'd1);

  // ---------------------------------------------------------------------------
  // Game FSM. Every output comes from a register in this block.
  // The first statement sets the free-running tick counter. Each state
  // change then overrides it with 0, so a new phase always starts with a
  // full second.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      target_q   <= '0;
      cursor_q   <= '0;
      sec_left_q <= '0;
      round_q    <= '0;
      show_q     <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      tick_q <= sec_tick ? '0 : tick_q + TW'(1);

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q  <= S_PICK;
            tick_q   <= '0;
            round_q  <= '0;
            cursor_q <= '0;
          end
        end

        S_PICK: begin
          if (cand_ok) begin
            state_q    <= S_SHOW;
            tick_q     <= '0;
            target_q   <= cand;
            sec_left_q <= SHOW_SEC_W;
            show_q     <= 1'b1;
          end
        end

        S_SHOW: begin
          if (last_sec) begin
            state_q    <= S_PLAY;
            tick_q     <= '0;
            sec_left_q <= PLAY_SEC_W;
            cursor_q   <= '0;
            show_q     <= 1'b0;
          end else if (sec_tick) begin
            sec_left_q <= sec_left_q - 4'd1;
          end
        end

        S_PLAY: begin
          // select takes priority over both the timeout and step. CHECK
          // therefore judges the cursor the player was looking at.
          if (select_i) begin
            state_q    <= S_CHECK;
            tick_q     <= '0;
            sec_left_q <= '0;
          end else if (last_sec) begin
            state_q    <= S_LOSE;
            tick_q     <= '0;
            sec_left_q <= '0;
            lose_q     <= 1'b1;
          end else begin
            if (step_i) begin
              cursor_q <= cursor_inc;
            end
            if (sec_tick) begin
              sec_left_q <= sec_left_q - 4'd1;
            end
          end
        end

        S_CHECK: begin
          tick_q <= '0;
          if (cursor_q == target_q) begin
            round_q <= round_inc;
            if (round_inc == ROUNDS_W) begin
              state_q <= S_WIN;
              win_q   <= 1'b1;
            end else begin
              state_q <= S_PICK;
            end
          end else begin
            state_q <= S_LOSE;
            lose_q  <= 1'b1;
          end
        end

        S_WIN, S_LOSE: begin
          if (start_i) begin
            state_q  <= S_PICK;
            tick_q   <= '0;
            round_q  <= '0;
            cursor_q <= '0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          tick_q  <= '0;
        end
      endcase
    end
  end

  assign state_o       = state_q;
  assign target_o      = target_q;
  assign cursor_o      = cursor_q;
  assign show_target_o = show_q;
  assign sec_left_o    = sec_left_q;
  assign round_o       = round_q;
  assign win_o         = win_q;
  assign lose_o        = lose_q;

endmodule
